// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART frame engines.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int unsigned PAR_EVEN = 0;
  localparam int unsigned PAR_ODD  = 1;

  // Serial bits in one frame: start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned data_w,
                                             input int unsigned parity_en,
                                             input int unsigned stop_bits);
    return 1 + data_w + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter; held at zero while clear is high.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end,
  output logic bit_pre_end
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (r_count == CNT_LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign bit_end = (r_count == CNT_LAST);
  // One cycle early, so consumers can register end-of-bit outputs.
  assign bit_pre_end = (r_count == CNT_PRE);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one word per valid/ready handshake, serialised as a full
// frame with optional parity and back-to-back streaming.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned IDX_W = $clog2(frame_bits(DATA_W, PARITY_EN, STOP_BITS));
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic PAR_INV = (PARITY_ODD == PAR_ODD);

  tx_state_t         r_state;
  logic [DATA_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_bit_idx;
  logic              r_parity;
  logic              r_txd;
  logic              r_tx_ready;
  logic              r_busy;
  logic              r_frame_done;

  logic w_bit_end;
  logic w_bit_pre_end;
  logic w_timer_clear;
  logic w_handshake;
  logic w_last_stop;

  // Timer runs only inside a frame; idle and unencoded states keep it at zero.
  assign w_timer_clear = !(r_state inside {START, DATA, PARITY, STOP});
  assign w_handshake   = tx_valid && r_tx_ready && (r_state inside {IDLE, STOP});
  assign w_last_stop   = (r_state == STOP) && (r_bit_idx == STOP_LAST);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (w_timer_clear),
    .bit_end    (w_bit_end),
    .bit_pre_end(w_bit_pre_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit_idx    <= '0;
      r_parity     <= 1'b0;
      r_txd        <= 1'b1;
      r_tx_ready   <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_txd      <= 1'b1;
          r_tx_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
        START: begin
          if (w_bit_end) begin
            r_state   <= DATA;
            r_txd     <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_idx <= '0;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == DATA_LAST) begin
              r_bit_idx <= '0;
              if (PARITY_EN != 0) begin
                r_state <= PARITY;
                r_txd   <= r_parity;
              end else begin
                r_state <= STOP;
                r_txd   <= 1'b1;
              end
            end else begin
              r_txd     <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_state   <= STOP;
            r_txd     <= 1'b1;
            r_bit_idx <= '0;
          end
        end
        STOP: begin
          // Raise ready/done for exactly the final cycle of the last stop bit.
          if (w_last_stop && w_bit_pre_end) begin
            r_frame_done <= 1'b1;
            r_tx_ready   <= 1'b1;
          end
          if (w_bit_end) begin
            if (w_last_stop) begin
              r_state   <= IDLE;
              r_busy    <= 1'b0;
              r_bit_idx <= '0;
            end else begin
              r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_txd      <= 1'b1;
          r_tx_ready <= 1'b1;
          r_busy     <= 1'b0;
          r_bit_idx  <= '0;
        end
      endcase

      // Accepting a word overrides the IDLE/STOP updates above.
      if (w_handshake) begin
        r_state    <= START;
        r_txd      <= 1'b0;
        r_shift    <= tx_data;
        r_parity   <= (^tx_data) ^ PAR_INV;
        r_bit_idx  <= '0;
        r_tx_ready <= 1'b0;
        r_busy     <= 1'b1;
      end
    end
  end

  assign tx_ready   = r_tx_ready;
  assign txd        = r_txd;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench: three parameterisations of uart_tx_frame, each with its own
// driver, reference frame model and serial-line monitor.
module tb_uart_tx_frame;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  bit done [3];

  task automatic check(input string name, input int cfg, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cfg%0d @%0t: got %0h, expected %0h", name, cfg, $time, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int DW    = (g == 1) ? 7 : 8;
    localparam int CPB   = (g == 1) ? 3 : 4;
    localparam int PEN   = (g == 2) ? 0 : 1;
    localparam bit PODD  = (g == 1);
    localparam int SB    = (g == 1) ? 2 : 1;
    localparam int TOTAL = (1 + DW + PEN + SB) * CPB;
    localparam int LIMIT = 4 * TOTAL + 20;

    logic          rst      = 1'b1;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data  = '0;
    logic          tx_ready, txd, busy, frame_done;

    logic [15:0] q[$];
    logic [15:0] cur;
    int          pos = -1;
    int          hs_cyc = 0;

    uart_tx_frame #(
      .DATA_W      (DW),
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (PEN),
      .PARITY_ODD  (PODD ? PAR_ODD : PAR_EVEN),
      .STOP_BITS   (SB)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .txd       (txd),
      .busy      (busy),
      .frame_done(frame_done)
    );

    // Expected line level per bit slot; slots past the data/parity stay 1 (stop).
    function automatic logic [15:0] model(input logic [DW-1:0] w);
      logic [15:0] f;
      int n;
      f    = '1;
      f[0] = 1'b0;
      n    = 1;
      for (int i = 0; i < DW; i++) begin
        f[n] = w[i];
        n++;
      end
      if (PEN != 0) f[n] = (($countones(w) % 2) == 1) ^ PODD;
      return f;
    endfunction

    always @(negedge clk) begin
      if (rst) begin
        pos = -1;
      end else begin
        if (pos < 0) begin
          if (txd === 1'b0) begin
            check("frame_expected", g, (q.size() > 0), 1);
            if (q.size() > 0) begin
              cur = q.pop_front();
              pos = 0;
            end
          end else begin
            check("idle_busy", g, busy, 0);
            check("idle_ready", g, tx_ready, 1);
            check("idle_done", g, frame_done, 0);
          end
        end
        if (pos >= 0) begin
          check("txd_bit", g, txd, cur[pos / CPB]);
          check("frame_busy", g, busy, 1);
          check("frame_done", g, frame_done, (pos == TOTAL - 1));
          check("frame_ready", g, tx_ready, (pos == TOTAL - 1));
          pos++;
          if (pos == TOTAL) pos = -1;
        end
      end
    end

    // Called on a negedge; returns on the negedge after the handshake edge.
    task automatic send(input logic [DW-1:0] w, input bit keep);
      int t;
      t        = 0;
      tx_valid = 1'b1;
      tx_data  = w;
      while (tx_ready !== 1'b1 && t < LIMIT) begin
        @(negedge clk);
        t++;
      end
      if (tx_ready !== 1'b1) begin
        check("ready_timeout", g, tx_ready, 1);
        tx_valid = 1'b0;
        return;
      end
      q.push_back(model(w));
      hs_cyc = cyc;
      @(negedge clk);
      check("start_latency", g, txd, 0);
      if (!keep) tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
      int t;
      t = 0;
      while (busy !== 1'b0 && t < LIMIT) begin
        @(negedge clk);
        t++;
      end
      check("idle_timeout", g, busy, 0);
    endtask

    initial begin
      int  hs1;
      bit  keep;
      repeat (3) @(negedge clk);
      check("rst_txd", g, txd, 1);
      check("rst_busy", g, busy, 0);
      check("rst_ready", g, tx_ready, 1);
      check("rst_done", g, frame_done, 0);
      rst = 1'b0;
      @(negedge clk);

      send(DW'(8'hA5), 1'b0); wait_idle();
      send(DW'(8'h01), 1'b0); wait_idle();
      send(DW'(8'h00), 1'b0); wait_idle();
      send(DW'(8'hFF), 1'b0); wait_idle();

      // Streaming: second start bit must follow the last stop cycle directly.
      send(DW'(8'h55), 1'b1);
      hs1 = hs_cyc;
      send(DW'(8'h3C), 1'b0);
      check("b2b_spacing", g, hs_cyc - hs1, TOTAL);
      wait_idle();

      // A word offered mid-frame must be dropped.
      send(DW'(8'hC3), 1'b0);
      repeat (3 * CPB) @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = DW'(8'h12);
      @(negedge clk);
      tx_valid = 1'b0;
      wait_idle();
      repeat (4) @(negedge clk);

      // Reset lands inside data bit 3.
      send(DW'(8'h6E), 1'b0);
      repeat (4 * CPB) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_txd", g, txd, 1);
      check("abort_busy", g, busy, 0);
      check("abort_ready", g, tx_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      send(DW'(8'h81), 1'b0); wait_idle();

      for (int i = 0; i < 12; i++) begin
        keep = (i < 11) && ($urandom_range(0, 1) == 1);
        send(DW'($urandom), keep);
        if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      tx_valid = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      check("queue_drained", g, q.size(), 0);
      done[g] = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(done[0] && done[1] && done[2]) && t < 50000) begin
      @(posedge clk);
      t++;
    end
    check("bench_complete", 0, (done[0] && done[1] && done[2]), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
